// File: rtl/arb_pkg.sv
// Shared types and helpers for the eight-way round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_REQ = 8;

  // Index of the first set bit of vec, scanning upward from ptr and wrapping 7->0.
  // Returns 0 when vec is empty; callers only use the result for non-empty vectors.
  function automatic logic [2:0] rotate_first(input logic [N_REQ-1:0] vec,
                                              input logic [2:0]       ptr);
    logic [2:0] idx;
    logic       found;
    rotate_first = 3'd0;
    found        = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 3'(i);
      if (!found && vec[idx]) begin
        rotate_first = idx;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/onehot_to_idx8.sv
// One-hot to 3-bit binary encoder. Output is meaningless for non-one-hot
// input; zero input encodes to 0, which gives gnt_idx its idle value for free.
module onehot_to_idx8 (
  input  logic [7:0] i_onehot,
  output logic [2:0] o_idx
);

  assign o_idx = {|(i_onehot & 8'hF0),
                  |(i_onehot & 8'hCC),
                  |(i_onehot & 8'hAA)};

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with grant lock and bounded hold time.
//
// state | meaning
// IDLE  | no grant outstanding, gnt = 0
// BUSY  | one requester holds gnt; hold counter tracks how long
//
// All outputs come straight from registers (gnt_idx through the encoder on
// registered gnt), so there is no combinational path from req or en.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            en,
  input  logic [7:0]                                      req,
  output logic [7:0]                                      gnt,
  output logic [2:0]                                      gnt_idx,
  output logic                                            gnt_valid,
  output logic [((MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1)-1:0] hold_cnt
);

  localparam int             HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        r_state, w_state_nx;
  logic [2:0]    r_ptr,   w_ptr_nx;
  logic [7:0]    r_gnt,   w_gnt_nx;
  logic [HW-1:0] r_hold,  w_hold_nx;
  logic [2:0]    w_idx;
  logic [2:0]    w_win;
  logic [7:0]    w_cand;
  logic          w_release;

  onehot_to_idx8 u_enc (
    .i_onehot (r_gnt),
    .o_idx    (w_idx)
  );

  // Next-state logic: pick a winner from IDLE, or keep/release/hand over in BUSY.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_gnt_nx   = r_gnt;
    w_hold_nx  = r_hold;
    w_win      = 3'd0;
    // The holder is masked out of the hand-over decision so a requester that
    // hit the hold limit cannot immediately win again.
    w_cand     = req & ~(8'd1 << w_idx);
    w_release  = !req[w_idx] || (r_hold == HOLD_LAST) || !en;

    case (r_state)
      IDLE: begin
        w_gnt_nx  = '0;
        w_hold_nx = '0;
        if (en && (|req)) begin
          w_win      = rotate_first(req, r_ptr);
          w_gnt_nx   = 8'd1 << w_win;
          w_state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!w_release) begin
          w_hold_nx = r_hold + 1'b1;
        end else begin
          w_ptr_nx  = w_idx + 3'd1;
          w_hold_nx = '0;
          if (en && (|w_cand)) begin
            w_win    = rotate_first(w_cand, w_idx + 3'd1);
            w_gnt_nx = 8'd1 << w_win;
          end else begin
            w_gnt_nx   = '0;
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
        w_hold_nx  = '0;
      end
    endcase
  end

  // State, pointer, grant and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_gnt   <= 8'h00;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_gnt   <= w_gnt_nx;
      r_hold  <= w_hold_nx;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = w_idx;
  assign gnt_valid = |r_gnt;
  assign hold_cnt  = r_hold;

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench: three arbiters (MAX_HOLD = 16, 4, 1) share one stimulus
// stream and are compared against a per-instance behavioural model.
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [7:0] g_o [3];
  logic [2:0] i_o [3];
  logic       v_o [3];
  logic [3:0] h16;
  logic [1:0] h4;
  logic [0:0] h1;

  int n_checks;
  int n_err;

  int mh [3] = '{16, 4, 1};
  bit m_busy [3];
  int m_idx  [3];
  int m_hold [3];
  int m_ptr  [3];

  rr_arb8 #(.MAX_HOLD(16)) u_mh16 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(g_o[0]), .gnt_idx(i_o[0]), .gnt_valid(v_o[0]), .hold_cnt(h16)
  );
  rr_arb8 #(.MAX_HOLD(4)) u_mh4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(g_o[1]), .gnt_idx(i_o[1]), .gnt_valid(v_o[1]), .hold_cnt(h4)
  );
  rr_arb8 #(.MAX_HOLD(1)) u_mh1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(g_o[2]), .gnt_idx(i_o[2]), .gnt_valid(v_o[2]), .hold_cnt(h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hold_of(input int k);
    case (k)
      0:       hold_of = {28'd0, h16};
      1:       hold_of = {30'd0, h4};
      default: hold_of = {31'd0, h1};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // First requester at or after position s, walking round the ring of eight.
  function automatic int first_set(input logic [7:0] v, input int s);
    for (int off = 0; off < 8; off++)
      if (v[(s + off) % 8]) return (s + off) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0;
      m_idx[k]  = 0;
      m_hold[k] = 0;
      m_ptr[k]  = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    logic [7:0] cand;
    for (int k = 0; k < 3; k++) begin
      if (!m_busy[k]) begin
        if (e && r != 8'h00) begin
          m_idx[k]  = first_set(r, m_ptr[k]);
          m_busy[k] = 1'b1;
          m_hold[k] = 0;
        end
      end else if (e && r[m_idx[k]] && m_hold[k] < mh[k] - 1) begin
        m_hold[k]++;
      end else begin
        m_ptr[k]  = (m_idx[k] + 1) % 8;
        m_hold[k] = 0;
        cand          = r;
        cand[m_idx[k]] = 1'b0;
        if (e && cand != 8'h00) m_idx[k] = first_set(cand, m_ptr[k]);
        else                    m_busy[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] eg;
    for (int k = 0; k < 3; k++) begin
      eg = m_busy[k] ? (32'd1 << m_idx[k]) : 32'd0;
      chk($sformatf("gnt_mh%0d", mh[k]),   {24'd0, g_o[k]}, eg);
      chk($sformatf("idx_mh%0d", mh[k]),   {29'd0, i_o[k]}, m_busy[k] ? 32'(m_idx[k]) : 32'd0);
      chk($sformatf("valid_mh%0d", mh[k]), {31'd0, v_o[k]}, {31'd0, m_busy[k]});
      chk($sformatf("hold_mh%0d", mh[k]),  hold_of(k),      32'(m_hold[k]));
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next.
  task automatic step(input logic [7:0] r, input logic e);
    req = r;
    en  = e;
    model_step(r, e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    req      = 8'h00;
    model_reset();

    #3;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2;
    rst_n = 1'b1;

    // Idle after reset with no requests.
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b1);
      chk("idle_valid", {31'd0, v_o[0]}, 32'd0);
    end

    // Fair rotation with MAX_HOLD=1: 0,1,...,7,0.
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1);
      chk("rot_idx", {29'd0, i_o[2]}, 32'(i % 8));
    end

    // Lock and release on MAX_HOLD=16.
    do_reset();
    step(8'h05, 1'b1);
    chk("lock_gnt", {24'd0, g_o[0]}, 32'h01);
    step(8'h05, 1'b1);
    step(8'h05, 1'b1);
    chk("lock_hold", {28'd0, h16}, 32'd2);
    step(8'h04, 1'b1);
    chk("rel_gnt", {24'd0, g_o[0]}, 32'h04);
    chk("rel_idx", {29'd0, i_o[0]}, 32'd2);
    chk("rel_hold", {28'd0, h16}, 32'd0);

    // Hold limit with a contender, MAX_HOLD=4.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(8'h03, 1'b1);
      chk("limit_idx", {29'd0, i_o[1]}, 32'((i / 4) % 2));
    end

    // Sole requester at the hold limit: four cycles, one idle, granted again.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(8'h01, 1'b1);
      chk("sole_valid", {31'd0, v_o[1]}, (i == 4) ? 32'd0 : 32'd1);
    end

    // Wrap-around on MAX_HOLD=1: idx 6 releases, scan starts at 7 and wraps to 0.
    do_reset();
    step(8'h40, 1'b1);
    chk("wrap_first", {29'd0, i_o[2]}, 32'd6);
    step(8'h41, 1'b1);
    chk("wrap_idx", {29'd0, i_o[2]}, 32'd0);

    // Enable dropped mid-grant on MAX_HOLD=16.
    do_reset();
    step(8'h08, 1'b1);
    chk("en_gnt", {24'd0, g_o[0]}, 32'h08);
    step(8'h08, 1'b0);
    chk("en_off", {24'd0, g_o[0]}, 32'h00);
    step(8'h08, 1'b0);
    chk("en_still_off", {31'd0, v_o[0]}, 32'd0);
    step(8'h08, 1'b1);
    chk("en_back", {29'd0, i_o[0]}, 32'd3);

    // Reset pulsed mid-grant clears outputs at once and restarts from ptr 0.
    step(8'hFF, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", {24'd0, g_o[0]}, 32'h00);
    check_all();
    #2;
    rst_n = 1'b1;
    step(8'hFF, 1'b1);
    chk("rst_restart", {29'd0, i_o[0]}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      e = ($urandom_range(0, 9) != 0);
      step(r, e);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
